// File: rtl/matb_stream_reader.sv
// Streams B-matrix rows from four lockstep SRAM banks as 512-bit beats, replaying the row range once per pass.
// state | meaning: IDLE wait for start | ISSUE bank reads under credit | DRAIN wait for last beat to leave | DONE one-cycle done pulse
module matb_stream_reader #(
  parameter int ADDR_WIDTH = 7,
  parameter int BANK_WIDTH = 128
) (
  input  logic                    vsi_clk,
  input  logic                    vsi_rstn,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [7:0]              row_count,
  input  logic [7:0]              pass_count,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   vsi_SRAM_oaddr1,
  output logic [ADDR_WIDTH-1:0]   vsi_SRAM_oaddr2,
  output logic [ADDR_WIDTH-1:0]   vsi_SRAM_oaddr3,
  output logic [ADDR_WIDTH-1:0]   vsi_SRAM_oaddr4,
  output logic                    vsi_SRAM_oen1,
  output logic                    vsi_SRAM_oen2,
  output logic                    vsi_SRAM_oen3,
  output logic                    vsi_SRAM_oen4,
  input  logic [BANK_WIDTH-1:0]   vsi_SRAM_odata1,
  input  logic [BANK_WIDTH-1:0]   vsi_SRAM_odata2,
  input  logic [BANK_WIDTH-1:0]   vsi_SRAM_odata3,
  input  logic [BANK_WIDTH-1:0]   vsi_SRAM_odata4,
  output logic [4*BANK_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    m_final
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_base, r_addr_hold, w_addr;
  logic [7:0]              r_row_cnt, r_pass_cnt, r_row_idx, r_pass_idx;
  logic                    w_issue, w_pop, w_credit_ok, w_last_row, w_final_row;
  logic                    r_rd_vld, r_rd_last, r_rd_final;
  logic [4*BANK_WIDTH-1:0] r_fifo_data [2];
  logic [1:0]              r_fifo_last, r_fifo_final;
  logic                    r_wptr, r_rptr;
  logic [1:0]              r_occ;

  assign w_addr      = r_base + r_row_idx[ADDR_WIDTH-1:0];
  assign w_pop       = m_valid & m_ready;
  // occ + inflight - pop < 2, rearranged so nothing underflows
  assign w_credit_ok = ({1'b0, r_occ} + {2'b00, r_rd_vld}) < (3'd2 + {2'b00, w_pop});
  assign w_last_row  = (r_row_idx == r_row_cnt - 8'd1);
  assign w_final_row = w_last_row && (r_pass_idx == r_pass_cnt - 8'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (row_count == 8'd0 || pass_count == 8'd0) w_state_nxt = ST_DONE;
          else                                          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_issue = w_credit_ok;
        if (w_issue && w_final_row) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!r_rd_vld && (r_occ == {1'b0, w_pop})) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge vsi_clk or negedge vsi_rstn) begin
    if (!vsi_rstn) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_ff @(posedge vsi_clk or negedge vsi_rstn) begin
    if (!vsi_rstn) begin
      r_base      <= '0;
      r_row_cnt   <= '0;
      r_pass_cnt  <= '0;
      r_row_idx   <= '0;
      r_pass_idx  <= '0;
      r_addr_hold <= '0;
      r_rd_vld    <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_final  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_base     <= base_addr;
        r_row_cnt  <= row_count;
        r_pass_cnt <= pass_count;
        r_row_idx  <= '0;
        r_pass_idx <= '0;
      end else if (w_issue) begin
        if (w_last_row) begin
          r_row_idx  <= '0;
          r_pass_idx <= r_pass_idx + 8'd1;
        end else begin
          r_row_idx  <= r_row_idx + 8'd1;
        end
      end
      if (w_issue) r_addr_hold <= w_addr;
      // tags ride alongside the one-cycle SRAM read latency
      r_rd_vld   <= w_issue;
      r_rd_last  <= w_last_row;
      r_rd_final <= w_final_row;
    end
  end

  always_ff @(posedge vsi_clk or negedge vsi_rstn) begin
    if (!vsi_rstn) begin
      for (int i = 0; i < 2; i++) r_fifo_data[i] <= '0;
      r_fifo_last  <= '0;
      r_fifo_final <= '0;
      r_wptr       <= 1'b0;
      r_rptr       <= 1'b0;
      r_occ        <= '0;
    end else begin
      if (r_rd_vld) begin
        r_fifo_data[r_wptr]  <= {vsi_SRAM_odata4, vsi_SRAM_odata3, vsi_SRAM_odata2, vsi_SRAM_odata1};
        r_fifo_last[r_wptr]  <= r_rd_last;
        r_fifo_final[r_wptr] <= r_rd_final;
        r_wptr               <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_occ <= r_occ + {1'b0, r_rd_vld} - {1'b0, w_pop};
    end
  end

  assign m_valid = (r_occ != 2'd0);
  assign m_data  = r_fifo_data[r_rptr];
  assign m_last  = r_fifo_last[r_rptr];
  assign m_final = r_fifo_final[r_rptr];

  assign busy = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
  assign done = (r_state == ST_DONE);

  assign vsi_SRAM_oen1   = w_issue;
  assign vsi_SRAM_oen2   = w_issue;
  assign vsi_SRAM_oen3   = w_issue;
  assign vsi_SRAM_oen4   = w_issue;
  assign vsi_SRAM_oaddr1 = w_issue ? w_addr : r_addr_hold;
  assign vsi_SRAM_oaddr2 = w_issue ? w_addr : r_addr_hold;
  assign vsi_SRAM_oaddr3 = w_issue ? w_addr : r_addr_hold;
  assign vsi_SRAM_oaddr4 = w_issue ? w_addr : r_addr_hold;

endmodule

// File: tb/tb_matb_stream_reader.sv
// Self-checking bench for matb_stream_reader: SRAM bank model, beat scoreboard, per-feature test tasks.
module tb_matb_stream_reader;

  logic         vsi_clk = 1'b0;
  logic         vsi_rstn = 1'b0;
  logic         start = 1'b0;
  logic [6:0]   base_addr = '0;
  logic [7:0]   row_count = '0, pass_count = '0;
  logic         busy, done;
  logic [6:0]   oaddr1, oaddr2, oaddr3, oaddr4;
  logic         oen1, oen2, oen3, oen4;
  logic [127:0] odata1 = '0, odata2 = '0, odata3 = '0, odata4 = '0;
  logic [511:0] m_data;
  logic         m_valid, m_last, m_final;
  logic         m_ready = 1'b1;

  matb_stream_reader #(.ADDR_WIDTH(7), .BANK_WIDTH(128)) dut (
    .vsi_clk(vsi_clk), .vsi_rstn(vsi_rstn), .start(start), .base_addr(base_addr),
    .row_count(row_count), .pass_count(pass_count), .busy(busy), .done(done),
    .vsi_SRAM_oaddr1(oaddr1), .vsi_SRAM_oaddr2(oaddr2), .vsi_SRAM_oaddr3(oaddr3), .vsi_SRAM_oaddr4(oaddr4),
    .vsi_SRAM_oen1(oen1), .vsi_SRAM_oen2(oen2), .vsi_SRAM_oen3(oen3), .vsi_SRAM_oen4(oen4),
    .vsi_SRAM_odata1(odata1), .vsi_SRAM_odata2(odata2), .vsi_SRAM_odata3(odata3), .vsi_SRAM_odata4(odata4),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_final(m_final)
  );

  always #5 vsi_clk = ~vsi_clk;

  int total = 0;
  int bad = 0;
  int beats_seen = 0;

  typedef struct {
    logic [511:0] data;
    logic         last;
    logic         fin;
  } beat_t;
  beat_t      exp_q[$];
  logic [6:0] addr_q[$];

  function automatic logic [127:0] bank_word(input int k, input logic [6:0] a);
    logic [31:0] h;
    h = 32'(a) * 32'd2654435761 + 32'(k);
    return {24'hB0B0B0, 8'(k), 25'd0, a, h, 32'hDEAD0000 | (32'(k) << 8) | 32'(a)};
  endfunction

  function automatic logic [511:0] beat_word(input logic [6:0] a);
    return {bank_word(4, a), bank_word(3, a), bank_word(2, a), bank_word(1, a)};
  endfunction

  // each bank returns data one cycle after its own read enable
  always @(posedge vsi_clk) begin
    if (oen1) odata1 <= bank_word(1, oaddr1);
    if (oen2) odata2 <= bank_word(2, oaddr2);
    if (oen3) odata3 <= bank_word(3, oaddr3);
    if (oen4) odata4 <= bank_word(4, oaddr4);
  end

  int           occ_tb = 0;
  int           infl_tb = 0;
  int           mon_pop;
  bit           stall_prev = 0;
  logic [511:0] data_prev;
  logic         last_prev, fin_prev;
  beat_t        got;

  always @(negedge vsi_clk) begin
    if (!vsi_rstn) begin
      occ_tb = 0;
      infl_tb = 0;
      stall_prev = 0;
    end else begin
      mon_pop = (m_valid && m_ready) ? 1 : 0;
      total++;
      if ({oen2, oen3, oen4} !== {3{oen1}} || {oaddr2, oaddr3, oaddr4} !== {3{oaddr1}}) begin
        bad++;
        $display("FAIL bank_lockstep: oen=%b%b%b%b oaddr=%0d,%0d,%0d,%0d, required all equal",
                 oen1, oen2, oen3, oen4, oaddr1, oaddr2, oaddr3, oaddr4);
      end
      if (oen1 === 1'b1) begin
        addr_q.push_back(oaddr1);
        total++;
        if (occ_tb + infl_tb - mon_pop >= 2) begin
          bad++;
          $display("FAIL credit: oen with occ=%0d inflight=%0d pop=%0d, required sum<2", occ_tb, infl_tb, mon_pop);
        end
      end
      if (stall_prev) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== data_prev || m_last !== last_prev || m_final !== fin_prev) begin
          bad++;
          $display("FAIL stall_hold: valid=%b last=%b final=%b data changed=%0d, required held beat",
                   m_valid, m_last, m_final, (m_data !== data_prev));
        end
      end
      if (mon_pop == 1) begin
        beats_seen++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat_extra: got beat last=%b final=%b, required no beat", m_last, m_final);
        end else begin
          got = exp_q.pop_front();
          if (m_data !== got.data || m_last !== got.last || m_final !== got.fin) begin
            bad++;
            $display("FAIL beat %0d: data=%h.. last=%b final=%b, required data=%h.. last=%b final=%b",
                     beats_seen, m_data[63:0], m_last, m_final, got.data[63:0], got.last, got.fin);
          end
        end
      end
      stall_prev = m_valid && !m_ready;
      data_prev  = m_data;
      last_prev  = m_last;
      fin_prev   = m_final;
      occ_tb     = occ_tb + infl_tb - mon_pop;
      infl_tb    = oen1 ? 1 : 0;
    end
  end

  // Drives one start cycle (cycle T) and queues the beats the job must produce.
  task automatic launch(input int b, input int rc, input int pc);
    @(posedge vsi_clk); #1;
    start      = 1'b1;
    base_addr  = 7'(b);
    row_count  = 8'(rc);
    pass_count = 8'(pc);
    addr_q.delete();
    for (int p = 0; p < pc; p++)
      for (int r = 0; r < rc; r++) begin
        beat_t e;
        e.data = beat_word(7'((b + r) % 128));
        e.last = (r == rc - 1);
        e.fin  = (r == rc - 1) && (p == pc - 1);
        exp_q.push_back(e);
      end
  endtask

  // Runs cycles T+1.. until done; reports the cycle offsets of interesting events.
  task automatic run_to_done(input int budget, input bit bp, output int done_k, output int first_oen,
                             output int first_vld, output int busy_cnt, output int vld_cnt);
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    done_k = -1; first_oen = -1; first_vld = -1; busy_cnt = 0; vld_cnt = 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge vsi_clk); #1;
      start   = 1'b0;
      m_ready = bp ? pat[(k - 1) % 4] : 1'b1;
      @(negedge vsi_clk);
      if (oen1 && first_oen < 0) first_oen = k;
      if (m_valid && first_vld < 0) first_vld = k;
      if (busy) busy_cnt++;
      if (m_valid) vld_cnt++;
      if (done) begin
        done_k = k;
        break;
      end
    end
    @(posedge vsi_clk); #1;
    m_ready = 1'b1;
  endtask

  task automatic check_addrs(input string name, input int b, input int rc, input int pc);
    int n = 0;
    int bad_i = -1;
    for (int p = 0; p < pc; p++)
      for (int r = 0; r < rc; r++) begin
        if (n < addr_q.size() && bad_i < 0 && addr_q[n] !== 7'((b + r) % 128)) bad_i = n;
        n++;
      end
    total++;
    if (addr_q.size() != n || bad_i >= 0) begin
      bad++;
      $display("FAIL %s_addrs: count=%0d first_bad_idx=%0d, required count=%0d from base %0d",
               name, addr_q.size(), bad_i, n, b);
    end
  endtask

  task automatic test_reset();
    vsi_rstn = 1'b0;
    repeat (2) @(negedge vsi_clk);
    total++;
    if ({busy, done, m_valid, m_last, m_final, oen1, oen2, oen3, oen4} !== 9'b0) begin
      bad++;
      $display("FAIL reset_ctrl: busy=%b done=%b valid=%b last=%b final=%b oen=%b%b%b%b, required all 0",
               busy, done, m_valid, m_last, m_final, oen1, oen2, oen3, oen4);
    end
    total++;
    if ({oaddr1, oaddr2, oaddr3, oaddr4} !== 28'd0 || m_data !== 512'd0) begin
      bad++;
      $display("FAIL reset_data: oaddr1=%0d m_data_lo=%h, required 0", oaddr1, m_data[63:0]);
    end
    @(posedge vsi_clk); #1;
    vsi_rstn = 1'b1;
  endtask

  task automatic test_basic();
    int dk, fo, fv, bc, vc;
    launch(0, 4, 1);
    run_to_done(40, 1'b0, dk, fo, fv, bc, vc);
    total++;
    if (fo !== 1 || fv !== 3) begin
      bad++;
      $display("FAIL basic_latency: first oen T+%0d first valid T+%0d, required T+1 and T+3", fo, fv);
    end
    total++;
    if (dk !== 7 || bc !== 6 || vc !== 4) begin
      bad++;
      $display("FAIL basic_timing: done T+%0d busy_cycles=%0d valid_cycles=%0d, required T+7 6 4", dk, bc, vc);
    end
    check_addrs("basic", 0, 4, 1);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL basic_beats: %0d beats missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_wrap_replay();
    int dk, fo, fv, bc, vc;
    launch(126, 4, 2);
    run_to_done(40, 1'b0, dk, fo, fv, bc, vc);
    check_addrs("wrap", 126, 4, 2);
    total++;
    if (dk !== 11 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL wrap_done: done T+%0d beats missing %0d, required T+11 and 0", dk, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int dk, fo, fv, bc, vc;
    int b0 = beats_seen;
    launch(40, 16, 1);
    run_to_done(200, 1'b1, dk, fo, fv, bc, vc);
    check_addrs("bp", 40, 16, 1);
    total++;
    if (dk < 0 || beats_seen - b0 != 16 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_delivery: done T+%0d beats=%0d missing=%0d, required done and 16 beats",
               dk, beats_seen - b0, exp_q.size());
    end
  endtask

  task automatic test_empty(input int rc, input int pc);
    int dk, fo, fv, bc, vc;
    launch(9, rc, pc);
    run_to_done(20, 1'b0, dk, fo, fv, bc, vc);
    repeat (3) @(negedge vsi_clk);
    total++;
    if (dk !== 1 || fo !== -1 || vc !== 0 || addr_q.size() != 0 || bc !== 0) begin
      bad++;
      $display("FAIL empty_%0dx%0d: done T+%0d first_oen=%0d valid_cycles=%0d busy_cycles=%0d, required T+1 none 0 0",
               rc, pc, dk, fo, vc, bc);
    end
  endtask

  task automatic test_start_while_busy();
    int dk = -1;
    int pulses = 0;
    launch(10, 6, 1);
    for (int k = 1; k <= 16; k++) begin
      @(posedge vsi_clk); #1;
      start = (k == 3);
      if (k == 3) begin
        base_addr = 7'd50;
        row_count = 8'd2;
      end
      @(negedge vsi_clk);
      if (done) begin
        pulses++;
        if (dk < 0) dk = k;
      end
    end
    check_addrs("busy_start", 10, 6, 1);
    total++;
    if (dk !== 9 || pulses !== 1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL busy_start_done: done T+%0d pulses=%0d missing=%0d, required T+9 1 0", dk, pulses, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_job();
    int b0 = beats_seen;
    int reached = 0;
    int done_seen = 0;
    int dk, fo, fv, bc, vc;
    launch(20, 20, 1);
    for (int k = 1; k <= 60; k++) begin
      @(posedge vsi_clk); #1;
      start = 1'b0;
      if (beats_seen - b0 >= 5) begin
        reached = 1;
        break;
      end
    end
    total++;
    if (reached == 0) begin
      bad++;
      $display("FAIL rst_mid_wait: beats=%0d, required 5 within budget", beats_seen - b0);
    end
    vsi_rstn = 1'b0;
    #1;
    total++;
    if ({busy, done, m_valid, m_last, m_final, oen1} !== 6'b0 || oaddr1 !== 7'd0 || m_data !== 512'd0) begin
      bad++;
      $display("FAIL rst_mid_outputs: busy=%b done=%b valid=%b oen=%b oaddr=%0d, required reset values",
               busy, done, m_valid, oen1, oaddr1);
    end
    exp_q.delete();
    repeat (2) begin
      @(negedge vsi_clk);
      if (done) done_seen++;
    end
    @(posedge vsi_clk); #1;
    vsi_rstn = 1'b1;
    repeat (3) begin
      @(negedge vsi_clk);
      if (done || busy) done_seen++;
    end
    total++;
    if (done_seen != 0) begin
      bad++;
      $display("FAIL rst_mid_no_done: done/busy cycles=%0d, required 0", done_seen);
    end
    launch(100, 3, 1);
    run_to_done(40, 1'b0, dk, fo, fv, bc, vc);
    check_addrs("rst_fresh", 100, 3, 1);
    total++;
    if (dk !== 6 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rst_fresh_done: done T+%0d missing=%0d, required T+6 0", dk, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_replay();
    test_backpressure();
    test_empty(0, 5);
    test_empty(3, 0);
    test_start_while_busy();
    test_reset_mid_job();
    repeat (2) @(negedge vsi_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required bench to finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
